// File: rtl/hough_bram_rd_arbiter_if.sv
// Requester/BRAM-side bundle for the hough BRAM read-port arbiter.
// Handshake: a beat transfers in any cycle where req[i] & gnt[i]; req/req_addr/req_last hold until then.
// Its response arrives on the next cycle as rsp_valid[i] with rsp_data, which the requester must accept.
interface hough_bram_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ADDR_WIDTH-1:0]         bram_rd_addr;
  logic [DATA_WIDTH-1:0]         bram_rd_data;
  logic                          busy;

  modport slave (
    input  req, req_addr, req_last, bram_rd_data,
    output gnt, rsp_valid, rsp_data, bram_rd_addr, busy
  );

  modport master (
    output req, req_addr, req_last, bram_rd_data,
    input  gnt, rsp_valid, rsp_data, bram_rd_addr, busy
  );
endinterface

// File: rtl/hough_bram_rd_arbiter.sv
// Round-robin arbiter with burst lock sharing one synchronous BRAM read port among NUM_REQ readers.
// The owner keeps the port until it flags last, drops req, or reaches MAX_BURST beats.
module hough_bram_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IMAGE_SIZE = 307200,
  parameter int ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  hough_bram_rd_arbiter_if.slave     bus,
  output logic                       dbg_state,
  output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           rr_q, rr_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [ADDR_WIDTH-1:0]   addr_q;

  logic                    hold;
  logic [PW-1:0]           scan_base;
  logic [PW-1:0]           j;
  logic [PW-1:0]           win;
  logic                    win_vld;
  logic                    win_last;
  logic [NUM_REQ-1:0]      gnt_w;
  logic [ADDR_WIDTH-1:0]   addr_w;
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Winner selection; a dropping owner hands off in the same cycle by scanning from owner+1.
  always_comb begin
    hold      = (state_q == BURST) && bus.req[owner_q];
    scan_base = (state_q == BURST) ? next_idx(owner_q) : rr_q;
    win       = owner_q;
    win_vld   = 1'b0;
    j         = scan_base;
    if (hold) begin
      win     = owner_q;
      win_vld = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_vld && bus.req[j]) begin
          win     = j;
          win_vld = 1'b1;
        end
        j = next_idx(j);
      end
    end
    win_last = bus.req_last[win];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      beat_q      <= '0;
      rsp_valid_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      beat_q      <= beat_d;
      rsp_valid_q <= gnt_w;
      addr_q      <= addr_w;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    if (hold) begin
      beat_d = beat_q + 1'b1;
      if (win_last || ((beat_q + 1'b1) == BW'(MAX_BURST))) begin
        state_d = IDLE;
        rr_d    = next_idx(owner_q);
        beat_d  = '0;
      end
    end else begin
      if (state_q == BURST) rr_d = next_idx(owner_q);
      state_d = IDLE;
      beat_d  = '0;
      if (win_vld) begin
        if (win_last || (MAX_BURST == 1)) begin
          rr_d = next_idx(win);
        end else begin
          state_d = BURST;
          owner_d = win;
          beat_d  = BW'(1);
        end
      end
    end
  end

  // The address register only follows granted beats, so an idle port keeps presenting the last address.
  always_comb begin
    gnt_w  = '0;
    addr_w = addr_q;
    if (reset && win_vld) begin
      gnt_w[win] = 1'b1;
      addr_w     = addr_arr[win];
    end
    bus.gnt          = gnt_w;
    bus.bram_rd_addr = addr_w;
    bus.rsp_valid    = rsp_valid_q;
    bus.rsp_data     = bus.bram_rd_data;
    bus.busy         = (state_q == BURST);
    dbg_state        = (state_q == BURST);
    dbg_rr_ptr       = rr_q;
  end

endmodule
